chien_search_p16: RTL and testbench



---
 rtl/bch_gf13_pkg.sv | 37 +++
 rtl/chien_sum_tree.sv | 24 ++
 rtl/chien_search_p16.sv | 196 +++++++++++++++++++
 tb/tb_chien_search_p16.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_gf13_pkg.sv
// Shared GF(2^13) BCH decoder definitions: field/code constants, element
// type, Chien search state encoding and flag-word payload.
package bch_gf13_pkg;

   localparam int unsigned M        = 13;
   localparam int unsigned P        = 16;
   localparam int unsigned CODE_LEN = 8191;
   localparam int unsigned NUM_BLK  = 512;
   localparam int unsigned BLK_W    = 9;
   localparam int unsigned CNT_W    = 14;
   localparam int unsigned POS_W    = 14;
   localparam int unsigned PC_W     = 5;

   typedef logic [M-1:0] gf13_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } chien_state_t;

   // One output word of the Chien search: root flags for 16 positions.
   typedef struct packed {
      logic [P-1:0]     flags;
      logic [BLK_W-1:0] blk_idx;
      logic             last;
   } chien_word_t;

   // Number of set flags in a word.
   function automatic logic [PC_W-1:0] popcount_p(input logic [P-1:0] v);
      logic [PC_W-1:0] n;
      n = '0;
      for (int i = 0; i < P; i++) n = n + PC_W'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/chien_sum_tree.sv
// XOR-reduces Lambda0 with the T column products of one evaluation point and
// flags a locator root (sum == 0).
//   lam0_i  : Lambda0
//   prod_i  : T products, product j at [j*M +: M]
//   zero_c  : combinational root flag
module chien_sum_tree
   import bch_gf13_pkg::*;
#(
   parameter int unsigned T = 8
) (
   input  logic [M-1:0]   lam0_i,
   input  logic [T*M-1:0] prod_i,
   output logic           zero_c
);

   logic [M-1:0] sum;

   always_comb begin
      sum = lam0_i;
      for (int j = 0; j < T; j++) sum = sum ^ prod_i[j*M +: M];
      zero_c = (sum == '0);
   end

endmodule

// File: rtl/chien_search_p16.sv
// 16-way parallel Chien search over GF(2^13). Holds Lambda1..LambdaT, drives
// them to external constant-multiplier columns, sums the returned products
// into 16 locator evaluations per cycle and emits one root-flag word per
// accepted cycle (512 words per codeword).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   lam_valid_i/lam_ready_o    locator load handshake (lam0_i, lam_i, deg_i)
//   coef_o                     coefficient registers to the multiplier columns
//   col_prod_i                 column products, col j prod k at ((j-1)*P+(k-1))*M
//   err_valid_o/err_ready_i    flag-word handshake
//   err_flags_o, blk_idx_o, err_last_o   flag word payload
//   root_cnt_o, fail_o         degree check results
// Optional feature macro: CHIEN_DEG_CHECK_EN (root count vs. degree check);
// without it root_cnt_o and fail_o are tied to zero.
module chien_search_p16
   import bch_gf13_pkg::*;
#(
   parameter int unsigned T = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             lam_valid_i,
   output logic             lam_ready_o,
   input  logic [M-1:0]     lam0_i,
   input  logic [T*M-1:0]   lam_i,
   input  logic [3:0]       deg_i,
   output logic [T*M-1:0]   coef_o,
   input  logic [T*P*M-1:0] col_prod_i,
   output logic             err_valid_o,
   input  logic             err_ready_i,
   output logic [P-1:0]     err_flags_o,
   output logic [BLK_W-1:0] blk_idx_o,
   output logic             err_last_o,
   output logic [CNT_W-1:0] root_cnt_o,
   output logic             fail_o
);

   chien_state_t     state_q, state_d;
   logic             lam_ready_q, lam_ready_d;
   logic             err_valid_q, err_valid_d;
   chien_word_t      word_q, word_d;
   logic [T*M-1:0]   coef_q, coef_d, coef_next_c;
   logic [M-1:0]     lam0_q, lam0_d;
   logic [BLK_W-1:0] c_q, c_d;
   logic [P-1:0]     root_c, flags_c;
   logic [POS_W-1:0] pos_c;
   logic             adv_c, accept_c;
   logic             load_c;

   // Per-position sum trees; column j product k regrouped by evaluation point.
   for (genvar k = 0; k < P; k++) begin : g_sum
      logic [T*M-1:0] prods;
      for (genvar j = 0; j < T; j++) begin : g_col
         assign prods[j*M +: M] = col_prod_i[(j*P+k)*M +: M];
      end
      chien_sum_tree #(.T(T)) u_sum (
         .lam0_i (lam0_q),
         .prod_i (prods),
         .zero_c (root_c[k])
      );
   end

   // The 16th product of each column is Lambda_j * alpha^(16j): next block's coefficient.
   for (genvar j = 0; j < T; j++) begin : g_next
      assign coef_next_c[j*M +: M] = col_prod_i[(j*P+P-1)*M +: M];
   end

   // Mask positions beyond the code length (only bit 15 of the last block).
   always_comb begin
      flags_c = '0;
      pos_c   = '0;
      for (int k = 0; k < P; k++) begin
         pos_c      = POS_W'(c_q) * POS_W'(P) + POS_W'(k+1);
         flags_c[k] = root_c[k] && (pos_c <= POS_W'(CODE_LEN));
      end
   end

   assign adv_c    = !err_valid_q || err_ready_i;
   assign accept_c = err_valid_q && err_ready_i;
   assign load_c   = (state_q == IDLE) && lam_valid_i;

   // Next-state and datapath control.
   always_comb begin
      state_d     = state_q;
      lam_ready_d = lam_ready_q;
      err_valid_d = err_valid_q;
      word_d      = word_q;
      coef_d      = coef_q;
      lam0_d      = lam0_q;
      c_d         = c_q;
      case (state_q)
         IDLE: begin
            lam_ready_d = 1'b1;
            if (lam_valid_i) begin
               coef_d      = lam_i;
               lam0_d      = lam0_i;
               c_d         = '0;
               lam_ready_d = 1'b0;
               state_d     = RUN;
            end
         end
         RUN: begin
            if (adv_c) begin
               word_d.flags   = flags_c;
               word_d.blk_idx = c_q;
               word_d.last    = (c_q == BLK_W'(NUM_BLK-1));
               err_valid_d    = 1'b1;
               coef_d         = coef_next_c;
               if (c_q == BLK_W'(NUM_BLK-1)) state_d = DRAIN;
               else                          c_d     = c_q + 1'b1;
            end
         end
         DRAIN: begin
            if (accept_c) begin
               err_valid_d = 1'b0;
               lam_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            lam_ready_d = 1'b1;
            err_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         lam_ready_q <= 1'b1;
         err_valid_q <= 1'b0;
         word_q      <= '0;
         coef_q      <= '0;
         lam0_q      <= '0;
         c_q         <= '0;
      end else begin
         state_q     <= state_d;
         lam_ready_q <= lam_ready_d;
         err_valid_q <= err_valid_d;
         word_q      <= word_d;
         coef_q      <= coef_d;
         lam0_q      <= lam0_d;
         c_q         <= c_d;
      end
   end

   assign lam_ready_o = lam_ready_q;
   assign err_valid_o = err_valid_q;
   assign err_flags_o = word_q.flags;
   assign blk_idx_o   = word_q.blk_idx;
   assign err_last_o  = word_q.last;
   assign coef_o      = coef_q;

`ifdef CHIEN_DEG_CHECK_EN
   logic [3:0]       deg_q, deg_d;
   logic [CNT_W-1:0] root_cnt_q, root_cnt_d;
   logic             fail_q, fail_d;

   // Accumulate roots over accepted words; compare with degree on the last one.
   always_comb begin
      deg_d      = deg_q;
      root_cnt_d = root_cnt_q;
      fail_d     = fail_q;
      if (load_c) begin
         deg_d      = deg_i;
         root_cnt_d = '0;
         fail_d     = 1'b0;
      end else if (accept_c) begin
         root_cnt_d = root_cnt_q + CNT_W'(popcount_p(word_q.flags));
         if (word_q.last) fail_d = (root_cnt_d != CNT_W'(deg_q));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deg_q      <= '0;
         root_cnt_q <= '0;
         fail_q     <= 1'b0;
      end else begin
         deg_q      <= deg_d;
         root_cnt_q <= root_cnt_d;
         fail_q     <= fail_d;
      end
   end

   assign root_cnt_o = root_cnt_q;
   assign fail_o     = fail_q;
`else
   logic unused_deg;
   assign unused_deg = ^{deg_i, load_c};
   assign root_cnt_o = '0;
   assign fail_o     = 1'b0;
`endif

endmodule

// File: tb/tb_chien_search_p16.sv
// Self-checking bench for chien_search_p16. Emulates the external multiplier
// columns and checks every flag word against a direct polynomial evaluation
// of Lambda(alpha^i) at each code position.
module tb_chien_search_p16;
   import bch_gf13_pkg::*;

   localparam int T  = 8;
   localparam int NQ = 8191;
   typedef logic [12:0] g_t;

   logic             clk;
   logic             rst_n;
   logic             lam_valid_i;
   logic             lam_ready_o;
   logic [12:0]      lam0_i;
   logic [T*13-1:0]  lam_i;
   logic [3:0]       deg_i;
   logic [T*13-1:0]  coef_o;
   logic [T*16*13-1:0] col_prod_i;
   logic             err_valid_o;
   logic             err_ready_i;
   logic [15:0]      err_flags_o;
   logic [8:0]       blk_idx_o;
   logic             err_last_o;
   logic [13:0]      root_cnt_o;
   logic             fail_o;

   int          n_tests;
   int          n_fail;
   int          exp_tab [NQ];
   bit          tab_ready;
   int          cur_lam0;
   int          cur_lam [1:8];
   int          cur_deg;
   logic [15:0] ref_flags [512];
   int          ref_roots;

   chien_search_p16 #(.T(T)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .lam_valid_i (lam_valid_i),
      .lam_ready_o (lam_ready_o),
      .lam0_i      (lam0_i),
      .lam_i       (lam_i),
      .deg_i       (deg_i),
      .coef_o      (coef_o),
      .col_prod_i  (col_prod_i),
      .err_valid_o (err_valid_o),
      .err_ready_i (err_ready_i),
      .err_flags_o (err_flags_o),
      .blk_idx_o   (blk_idx_o),
      .err_last_o  (err_last_o),
      .root_cnt_o  (root_cnt_o),
      .fail_o      (fail_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // GF(2^13) multiply, field polynomial x^13+x^4+x^3+x+1.
   function automatic int gf_mul(input int a, input int b);
      int r;
      int aa;
      r  = 0;
      aa = a;
      for (int i = 0; i < 13; i++) begin
         if (((b >> i) & 1) != 0) r = r ^ aa;
         aa = aa << 1;
         if ((aa & 'h2000) != 0) aa = aa ^ 'h201B;
      end
      return r;
   endfunction

   // External multiplier columns: column j, product k = coef_j * alpha^(j*k).
   always @(coef_o or tab_ready) begin
      for (int j = 0; j < T; j++)
         for (int k = 0; k < 16; k++)
            col_prod_i[(j*16+k)*13 +: 13] =
               g_t'(gf_mul(int'(coef_o[j*13 +: 13]), exp_tab[((j+1)*(k+1)) % NQ]));
   end

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference flags: Lambda(alpha^i) == 0 for each position i = 16c+k <= 8191.
   task automatic build_ref();
      ref_roots = 0;
      for (int c = 0; c < 512; c++) begin
         ref_flags[c] = '0;
         for (int k = 1; k <= 16; k++) begin
            int i;
            int v;
            i = 16*c + k;
            if (i <= 8191) begin
               v = cur_lam0;
               for (int j = 1; j <= 8; j++) v = v ^ gf_mul(cur_lam[j], exp_tab[(j*i) % NQ]);
               if (v == 0) begin
                  ref_flags[c][k-1] = 1'b1;
                  ref_roots++;
               end
            end
         end
      end
   endtask

   task automatic check_reset_vals();
      check_eq("rst_lam_ready", 128'(lam_ready_o), 128'(1));
      check_eq("rst_err_valid", 128'(err_valid_o), 128'(0));
      check_eq("rst_err_flags", 128'(err_flags_o), 128'(0));
      check_eq("rst_blk_idx",   128'(blk_idx_o),   128'(0));
      check_eq("rst_err_last",  128'(err_last_o),  128'(0));
      check_eq("rst_coef",      128'(coef_o),      128'(0));
      check_eq("rst_root_cnt",  128'(root_cnt_o),  128'(0));
      check_eq("rst_fail",      128'(fail_o),      128'(0));
   endtask

   task automatic set_two_roots(input int deg);
      cur_lam0 = 1;
      for (int j = 1; j <= 8; j++) cur_lam[j] = 0;
      cur_lam[1] = exp_tab[8171] ^ 1;   // (1 + a^-20 x)(1 + x)
      cur_lam[2] = exp_tab[8171];
      cur_deg    = deg;
   endtask

   // Load current Lambda, consume one codeword with random backpressure.
   task automatic run_codeword(input int ready_pct, input bit spam, input int abort_blk);
      logic [T*13-1:0] lam_pk;
      logic [26:0]     held_out;
      logic [T*13-1:0] held_coef;
      int              blk;
      int              cyc;
      int              wait_cnt;
      bit              stalled;
      bit              done;
      build_ref();
      for (int j = 1; j <= 8; j++) lam_pk[(j-1)*13 +: 13] = g_t'(cur_lam[j]);
      wait_cnt = 0;
      while (!lam_ready_o && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      check_eq("ready_before_load", 128'(lam_ready_o), 128'(1));
      if (!lam_ready_o) return;
      lam0_i      = g_t'(cur_lam0);
      lam_i       = lam_pk;
      deg_i       = 4'(cur_deg);
      lam_valid_i = 1'b1;
      @(negedge clk);
      check_eq("load_coef",       128'(coef_o),      128'(lam_pk));
      check_eq("busy_after_load", 128'(lam_ready_o), 128'(0));
      check_eq("no_word_at_load", 128'(err_valid_o), 128'(0));
      check_eq("load_clr_root",   128'(root_cnt_o),  128'(0));
      check_eq("load_clr_fail",   128'(fail_o),      128'(0));
      if (spam) begin
         for (int j = 0; j < T; j++) lam_i[j*13 +: 13] = g_t'($urandom);
         lam0_i = g_t'($urandom);
         deg_i  = 4'($urandom);
      end else begin
         lam_valid_i = 1'b0;
      end
      blk = 0; cyc = 0; stalled = 1'b0; done = 1'b0;
      held_out = '0; held_coef = '0;
      while (!done && cyc < 20000) begin
         if (stalled) begin
            check_eq("stall_hold_out",  128'({err_valid_o, err_flags_o, blk_idx_o, err_last_o}), 128'(held_out));
            check_eq("stall_hold_coef", 128'(coef_o), 128'(held_coef));
         end
         if (cyc == 1) begin
            check_eq("first_word_valid", 128'(err_valid_o), 128'(1));
            check_eq("first_word_idx",   128'(blk_idx_o),   128'(0));
         end
         err_ready_i = ($urandom_range(99) < ready_pct);
         if (err_valid_o && err_ready_i) begin
            check_eq("flags",   128'(err_flags_o), 128'(ref_flags[blk]));
            check_eq("blk_idx", 128'(blk_idx_o),   128'(blk));
            check_eq("last",    128'(err_last_o),  128'(blk == 511));
            if (blk == 511) begin
               lam_valid_i = 1'b0;
               done        = 1'b1;
            end
            if (blk == abort_blk) begin
               lam_valid_i = 1'b0;
               @(posedge clk);
               #2 rst_n = 1'b0;
               #1 check_reset_vals();
               @(negedge clk);
               @(negedge clk);
               rst_n = 1'b1;
               @(negedge clk);
               return;
            end
            blk++;
         end
         stalled   = err_valid_o && !err_ready_i;
         held_out  = {err_valid_o, err_flags_o, blk_idx_o, err_last_o};
         held_coef = coef_o;
         @(negedge clk);
         cyc++;
      end
      if (!done) begin
         check_eq("codeword_timeout", 128'(blk), 128'(512));
         return;
      end
      check_eq("ready_after_last", 128'(lam_ready_o), 128'(1));
      check_eq("valid_after_last", 128'(err_valid_o), 128'(0));
`ifdef CHIEN_DEG_CHECK_EN
      check_eq("root_cnt", 128'(root_cnt_o), 128'(ref_roots));
      check_eq("fail",     128'(fail_o),     128'(ref_roots != cur_deg));
`else
      check_eq("root_cnt", 128'(root_cnt_o), 128'(0));
      check_eq("fail",     128'(fail_o),     128'(0));
`endif
   endtask

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      tab_ready   = 1'b0;
      rst_n       = 1'b0;
      lam_valid_i = 1'b0;
      lam0_i      = '0;
      lam_i       = '0;
      deg_i       = '0;
      err_ready_i = 1'b0;
      exp_tab[0]  = 1;
      for (int n = 1; n < NQ; n++) exp_tab[n] = gf_mul(exp_tab[n-1], 2);
      tab_ready = 1'b1;

      repeat (3) @(negedge clk);
      check_reset_vals();
      rst_n = 1'b1;
      @(negedge clk);

      // No roots at all.
      cur_lam0 = 1;
      for (int j = 1; j <= 8; j++) cur_lam[j] = 0;
      cur_deg = 0;
      run_codeword(100, 1'b0, -1);

      // Single root at alpha^5.
      cur_lam[1] = exp_tab[8186];
      cur_deg    = 1;
      run_codeword(100, 1'b0, -1);

      // Same locator, 50% backpressure, load requests ignored while busy.
      run_codeword(50, 1'b1, -1);

      // Roots at alpha^20 and alpha^8191; position 8192 masked.
      set_two_roots(2);
      run_codeword(100, 1'b0, -1);

      // Abort mid-codeword, then restart from block 0.
      cur_lam0 = 1;
      for (int j = 1; j <= 8; j++) cur_lam[j] = 0;
      cur_lam[1] = exp_tab[8186];
      cur_deg    = 1;
      run_codeword(80, 1'b0, 100);
      set_two_roots(2);
      run_codeword(70, 1'b0, -1);

      // Degree disagrees with root count.
      set_two_roots(3);
      run_codeword(90, 1'b0, -1);

      // Random locators.
      for (int r = 0; r < 2; r++) begin
         cur_lam0 = int'($urandom_range(8191, 1));
         for (int j = 1; j <= 8; j++) cur_lam[j] = int'($urandom_range(8191, 0));
         cur_deg = int'($urandom_range(15, 0));
         run_codeword(60, r[0], -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
